// File: rtl/dmem_pkg.sv
// Shared types and helpers for the DMEM responder: FSM states, funct3 access
// codes, byte-lane selection and access legality.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'b0001 << off;
      F3_H, F3_HU: m = 4'b0011 << off;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  // Misalignment, reserved encodings, unsigned stores and read+write together.
  function automatic logic access_err(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] off);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_BU:   e = wr;
      F3_H:    e = off[0];
      F3_HU:   e = off[0] | wr;
      F3_W:    e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e | (rd & wr);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed 32-bit RAM built from four byte lanes; registered read,
// byte-enabled write on the same edge (read-during-write returns old data).
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [0:DEPTH-1];
      logic [7:0] r_q;

      always_ff @(posedge i_clk) begin
        if (i_be[gi]) begin
          r_mem[i_addr] <= i_wdata[gi*8 +: 8];
        end
        r_q <= r_mem[i_addr];
      end

      assign o_rdata[gi*8 +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// DMEM responder: accepts one load/store, waits WAIT_STATES cycles, commits the
// access on the edge entering RESP and strobes mem_ready for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [1:0]        byte_off,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] write_data_DMEM,
  output logic [DATA_W-1:0] data_DMEM,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int              WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0]      WS_INIT = 3'(WS_M1);
  localparam logic            NO_WAIT = (WAIT_STATES == 0);

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_off;
  logic [2:0]          r_f3;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rd;
  logic                r_wr;
  logic                r_ready;
  logic                r_err;
  logic [DATA_W-1:0]   r_data;

  logic                w_idle;
  logic                w_req;
  logic                w_cur_rd;
  logic                w_cur_wr;
  logic [ADDR_W-1:0]   w_cur_addr;
  logic [1:0]          w_cur_off;
  logic [2:0]          w_cur_f3;
  logic [DATA_W-1:0]   w_cur_wdata;
  logic                w_cur_err;
  logic                w_commit;
  logic [3:0]          w_be;
  logic [DATA_W-1:0]   w_store_data;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_load;
  logic [DATA_W-1:0]   w_resp_data;

  // In IDLE the live inputs describe the access (needed when it commits with no
  // wait states); afterwards the captured copy does.
  assign w_idle      = (r_state == IDLE);
  assign w_req       = MemRead | MemWrite;
  assign w_cur_rd    = w_idle ? MemRead         : r_rd;
  assign w_cur_wr    = w_idle ? MemWrite        : r_wr;
  assign w_cur_addr  = w_idle ? address_DMEM    : r_addr;
  assign w_cur_off   = w_idle ? byte_off        : r_off;
  assign w_cur_f3    = w_idle ? funct3          : r_f3;
  assign w_cur_wdata = w_idle ? write_data_DMEM : r_wdata;
  assign w_cur_err   = access_err(w_cur_rd, w_cur_wr, w_cur_f3, w_cur_off);

  assign w_commit = w_idle ? (w_req & NO_WAIT) : ((r_state == WAIT) && (r_cnt == 3'd0));
  assign w_be     = (w_commit && w_cur_wr && !w_cur_err) ? lane_mask(w_cur_f3, w_cur_off) : 4'b0000;

  always_comb begin
    w_store_data = w_cur_wdata;
    case (w_cur_f3)
      F3_B:    w_store_data = {4{w_cur_wdata[7:0]}};
      F3_H:    w_store_data = {2{w_cur_wdata[15:0]}};
      default: w_store_data = w_cur_wdata;
    endcase
  end

  dmem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (CLK),
    .i_addr (w_cur_addr),
    .i_be   (w_be),
    .i_wdata(w_store_data),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_shift = w_rdata >> {r_off, 3'b000};
    w_load  = w_rdata;
    case (r_f3)
      F3_B:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   w_load = {24'b0, w_shift[7:0]};
      F3_H:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   w_load = {16'b0, w_shift[15:0]};
      default: w_load = w_rdata;
    endcase
    w_resp_data = r_err ? '0 : w_load;
  end

  // The RAM read port is registered, so load data is formed from it during RESP
  // and captured into r_data to hold until the next load.
  assign data_DMEM = ((r_state == RESP) && r_rd) ? w_resp_data : r_data;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_off   <= 2'b00;
      r_f3    <= 3'b000;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (w_req) begin
            r_addr  <= address_DMEM;
            r_off   <= byte_off;
            r_f3    <= funct3;
            r_wdata <= write_data_DMEM;
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            if (NO_WAIT) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= w_cur_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WS_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_err   <= w_cur_err;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (r_rd) begin
            r_data <= w_resp_data;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
